// File: rtl/branch_pkg.sv
// Shared branch-resolution constants: funct3 condition codes and the flush FSM encoding.
// Imported by branch_cond and branch_resolve.
package branch_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Wide enough for the deepest legal flush (3 stages).
    localparam int CNT_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/branch_cond.sv
// Purely combinational branch-condition decode from subtract flags (rs1 - rs2).
// funct3 codes 010/011 have no branch meaning: never taken, flagged illegal.
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zf_i,
    input  logic       cf_i,
    input  logic       vf_i,
    input  logic       sf_i,
    output logic       cond_o,
    output logic       illegal_o
);

    always_comb begin
        cond_o    = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            BEQ:     cond_o = zf_i;
            BNE:     cond_o = ~zf_i;
            BLT:     cond_o = sf_i ^ vf_i;
            BGE:     cond_o = ~(sf_i ^ vf_i);
            // Carry is set when no borrow occurred, so unsigned-less-than is !cf.
            BLTU:    cond_o = ~cf_i;
            BGEU:    cond_o = cf_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: one-cycle redirect strobe plus a FLUSH_DEPTH-cycle kill of younger stages.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic [2:0]  funct3_i,
    input  logic        zf_i,
    input  logic        cf_i,
    input  logic        vf_i,
    input  logic        sf_i,
    input  logic [31:0] target_i,
    input  logic        stall_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        illegal_o,
    output logic [31:0] br_count_o,
    output logic [31:0] taken_count_o
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_DEPTH);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_redirect;
    logic [31:0]       r_redirect_pc;
    logic              r_illegal;

    logic w_cond;
    logic w_f3_illegal;
    logic w_accept;
    logic w_taken;
    logic w_illegal;

    branch_cond u_cond (
        .funct3_i  (funct3_i),
        .zf_i      (zf_i),
        .cf_i      (cf_i),
        .vf_i      (vf_i),
        .sf_i      (sf_i),
        .cond_o    (w_cond),
        .illegal_o (w_f3_illegal)
    );

    // Anything arriving while flushing is wrong-path and is dropped entirely.
    assign w_accept  = valid_i & ~stall_i & (r_state == IDLE);
    assign w_taken   = w_accept & (jump_i | (branch_i & w_cond));
    assign w_illegal = w_accept & branch_i & ~jump_i & w_f3_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_illegal     <= 1'b0;
        end else begin
            r_redirect <= w_taken;
            r_illegal  <= w_illegal;
            if (w_taken) begin
                r_redirect_pc <= target_i;
            end
            case (r_state)
                IDLE: begin
                    if (w_taken) begin
                        r_state <= FLUSH;
                        r_cnt   <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (!stall_i) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign flush_o       = (r_state == FLUSH);
    assign illegal_o     = r_illegal;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_taken_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            if (w_accept & (branch_i | jump_i)) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (w_taken) begin
                r_taken_count <= r_taken_count + 32'd1;
            end
        end
    end

    assign br_count_o    = r_br_count;
    assign taken_count_o = r_taken_count;
`else
    assign br_count_o    = '0;
    assign taken_count_o = '0;
`endif

endmodule
